// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, through one shared DIGIT-bit adder. Valid/ready handshakes on both sides.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
    logic             carry;
    logic             a_msb, b_msb;
    logic [WIDTH-1:0] b_eff;
    logic             carry_init;
    logic [DIGIT:0]   digit_sum;
    logic             accept, last_step;

    // Effective B operand and initial carry: subtraction is a + ~b + 1
`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff      = sub ? ~b : b;
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign b_eff      = b;
    assign carry_init = cin;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == RUN) && (count == LAST);

    // The single shared digit adder; its top bit is the digit carry-out
    assign digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};

    // Result register shifts right, new digit enters at the top
    always_comb begin
        acc_next = acc >> DIGIT;
        acc_next[WIDTH-1 -: DIGIT] = digit_sum[DIGIT-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (count == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Step counter: cleared on accept, stops at the last step
    always_ff @(posedge clk) begin
        if (!rst_n)                          count <= '0;
        else if (accept)                     count <= '0;
        else if (state == RUN && !last_step) count <= count + CW'(1);
    end

    // Published result: updated only on the final step, held otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else if (last_step) begin
            sum <= acc_next;
            co  <= digit_sum[DIGIT];
            ovf <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
        end
    end

    // Operand shifters, running carry and captured sign bits (data only, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= carry_init;
            a_msb <= a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            acc   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            carry <= digit_sum[DIGIT];
            acc   <= acc_next;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: four instances (W8/D1, W8/D2, W8/D4, W16/D16).
// Stimulus pushes expected results; a monitor pops and compares on each output handshake.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  iv;
    logic        out_ready;
    logic [15:0] a, b;
    logic        cin, sub;
    wire  [3:0]  ir, ov, co_v, ovf_v;
    wire  [7:0]  s1, s2, s4;
    wire  [15:0] s16;
    logic [15:0] sm [4];

    typedef struct {
        int          id;
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [3:0]  ov_prev = 4'b0;
    int          lat [4] = '{8, 4, 2, 1};

    serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[0]), .out_ready(out_ready), .sum(s1), .co(co_v[0]), .ovf(ovf_v[0]));

    serial_adder #(.WIDTH(8), .DIGIT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[1]), .out_ready(out_ready), .sum(s2), .co(co_v[1]), .ovf(ovf_v[1]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[2]), .out_ready(out_ready), .sum(s4), .co(co_v[2]), .ovf(ovf_v[2]));

    serial_adder #(.WIDTH(16), .DIGIT(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[3]), .out_ready(out_ready), .sum(s16), .co(co_v[3]), .ovf(ovf_v[3]));

    always_comb begin
        sm[0] = {8'h00, s1};
        sm[1] = {8'h00, s2};
        sm[2] = {8'h00, s4};
        sm[3] = s16;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, values on each handshake
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_n && ov[i] && !ov_prev[i])
                chk($sformatf("latency_dut%0d", i), 16'(cyc - acc_cyc), 16'(lat[i]));
            if (rst_n && ov[i] && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output dut%0d: sum %h, no result expected", i, sm[i]);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("id_dut%0d", i), 16'(i), 16'(e.id));
                    chk($sformatf("sum_dut%0d", i), sm[i], e.s);
                    chk($sformatf("co_dut%0d", i), 16'(co_v[i]), 16'(e.c));
                    chk($sformatf("ovf_dut%0d", i), 16'(ovf_v[i]), 16'(e.o));
                end
            end
        end
        ov_prev = ov;
    end

    // Issue one operand pair to DUT 'id' and push its expected result
    task automatic send(input int id, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic s, input logic [15:0] es,
                        input logic eco, input logic eo);
        exp_t t;
        t.id = id; t.s = es; t.c = eco; t.o = eo;
        q.push_back(t);
        a = av; b = bv; cin = c; sub = s;
        iv[id] = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        iv[id] = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been consumed
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; iv = 4'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 16'(ir), 16'hF);
        chk("rst_out_valid", 16'(ov), 16'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_sum_dut%0d", i), sm[i], 16'h0);
        chk("rst_co", 16'(co_v), 16'h0);
        chk("rst_ovf", 16'(ovf_v), 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // W8/D1 additions
        send(0, 16'h5A, 16'h33, 1'b0, 1'b0, 16'h8D, 1'b0, 1'b1); drain();
        send(0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0); drain();
        send(0, 16'hFF, 16'h00, 1'b1, 1'b0, 16'h00, 1'b1, 1'b0); drain();
        send(0, 16'h80, 16'h80, 1'b0, 1'b0, 16'h00, 1'b1, 1'b1); drain();
        // W8/D2, W8/D4, W16/D16
        send(1, 16'h0F, 16'h01, 1'b0, 1'b0, 16'h10, 1'b0, 1'b0); drain();
        send(2, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1); drain();
        send(2, 16'hA5, 16'h5A, 1'b1, 1'b0, 16'h00, 1'b1, 1'b0); drain();
        send(3, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0); drain();
        send(3, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1); drain();
        send(3, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1); drain();
`ifdef SERIAL_ADDER_SUB_EN
        send(1, 16'h10, 16'h20, 1'b1, 1'b1, 16'hF0, 1'b0, 1'b0); drain();
        send(1, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1); drain();
`endif

        // Backpressure on W8/D1: result held, in_valid ignored
        out_ready = 1'b0;
        send(0, 16'h5A, 16'h33, 1'b0, 1'b0, 16'h8D, 1'b0, 1'b1);
        n = 0;
        while (!ov[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_reached", 16'(ov[0]), 16'h1);
        for (int k = 0; k < 5; k++) begin
            iv[0] = ~k[0];
            a = 16'h0011; b = 16'h0022;
            @(posedge clk); #1;
            chk("bp_out_valid", 16'(ov[0]), 16'h1);
            chk("bp_sum", sm[0], 16'h8D);
            chk("bp_co", 16'(co_v[0]), 16'h0);
            chk("bp_ovf", 16'(ovf_v[0]), 16'h1);
            chk("bp_in_ready", 16'(ir[0]), 16'h0);
        end
        iv[0] = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_queued_op", 16'(ov[0]), 16'h0);
        chk("bp_idle", 16'(ir[0]), 16'h1);
        chk("hold_sum_idle", sm[0], 16'h8D);

        // Reset at the third RUN edge discards the operation
        a = 16'h11; b = 16'h22; cin = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 16'(ir[0]), 16'h1);
        chk("midrst_out_valid", 16'(ov[0]), 16'h0);
        chk("midrst_sum", sm[0], 16'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_output", 16'(ov[0]), 16'h0);
        send(0, 16'h12, 16'h34, 1'b1, 1'b0, 16'h47, 1'b0, 1'b0); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
